// File: rtl/progmem_loader_if.sv
// rtl/progmem_loader_if.sv - byte stream in and program-memory write bus out of the loader
// master is the loader side; slave is the host/memory environment side.
interface progmem_loader_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_waddr;
    logic [INST_W-1:0] pm_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output pm_we,
        output pm_waddr,
        output pm_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  pm_we,
        input  pm_waddr,
        input  pm_wdata
    );
endinterface

// File: rtl/progmem_loader.sv
// rtl/progmem_loader.sv - assembles a byte stream into little-endian words and writes program memory
// The core stays disabled from an accepted start until the last requested word is written.
module progmem_loader #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W:0]   word_count_i,
    output logic              core_en_o,
    output logic              busy_o,
    output logic              done_o,
    progmem_loader_if.master  bus
);
    localparam int BPW   = INST_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BPW - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [INST_W-1:0] word_q;
    logic              rx_ready_q;
    logic              pm_we_q;
    logic [ADDR_W-1:0] pm_waddr_q;
    logic [INST_W-1:0] pm_wdata_q;
    logic              core_en_q;
    logic              busy_q;
    logic              done_q;

    logic              byte_fire;
    logic [INST_W-1:0] word_d;
    logic [ADDR_W:0]   start_count;

    always_comb begin
        byte_fire   = (state_q == LOAD) && bus.rx_valid;
        word_d      = word_q;
        for (int k = 0; k < BPW; k++) begin
            if (idx_q == IDX_W'(k)) begin
                word_d[8*k +: 8] = bus.rx_data;
            end
        end
        // A count beyond the memory depth would only rewrite wrapped addresses.
        start_count = (word_count_i > DEPTH) ? DEPTH : word_count_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            rx_ready_q <= 1'b0;
            pm_we_q    <= 1'b0;
            pm_waddr_q <= '0;
            pm_wdata_q <= '0;
            core_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        count_q   <= start_count;
                        addr_q    <= '0;
                        idx_q     <= '0;
                        done_q    <= 1'b0;
                        core_en_q <= 1'b0;
                        if (start_count != '0) begin
                            state_q    <= LOAD;
                            rx_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (state_q == DONE) begin
                        // Also re-raises the flags one cycle after a zero-length start.
                        done_q    <= 1'b1;
                        core_en_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (byte_fire) begin
                        word_q <= word_d;
                        if (idx_q == LAST_IDX) begin
                            state_q    <= WRITE;
                            rx_ready_q <= 1'b0;
                            pm_we_q    <= 1'b1;
                            pm_waddr_q <= addr_q;
                            pm_wdata_q <= word_d;
                            idx_q      <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end
                end
                WRITE: begin
                    pm_we_q <= 1'b0;
                    addr_q  <= addr_q + ADDR_ONE;
                    count_q <= count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        core_en_q <= 1'b1;
                    end else begin
                        state_q    <= LOAD;
                        rx_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.pm_we    = pm_we_q;
    assign bus.pm_waddr = pm_waddr_q;
    assign bus.pm_wdata = pm_wdata_q;
    assign core_en_o    = core_en_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule

// File: doc/progmem_loader.md
Name: progmem_loader

Overview:
Writer side of the core's instruction-fetch interface. Receives a byte-serial program image over a valid/ready stream and assembles it into INST_W-bit little-endian words. Writes the words into program memory at consecutive addresses starting from 0. Holds the core disabled (core_en low) while loading and releases it once the requested word count has been written. Sits between the host/debug link and the program memory that CORE reads through progmem_addr/progmem_data.

Parameters:
INST_W, 32, instruction word width in bits; must be a multiple of 8 (BPW = INST_W/8 bytes per word).
ADDR_W, 8, program memory word-address width; depth = 2^ADDR_W words.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE
word_count  input  ADDR_W+1  number of words to load, latched on accepted start
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
pm_we  output  1  program memory write strobe, one cycle per word
pm_waddr  output  ADDR_W  program memory word address
pm_wdata  output  INST_W  program memory write data
core_en  output  1  drives CORE en; high only after a completed load
busy  output  1  high in LOAD and WRITE
done  output  1  sticky completion flag; cleared by the next accepted start

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0: rx_ready, pm_we, pm_waddr, pm_wdata, core_en, busy, done. Byte index, word counter and assembly register are cleared.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE with start=1:
  - Latch count = min(word_count, 2^ADDR_W), addr=0, byte idx=0.
  - Clear done and core_en in the next cycle.
  - Next state is LOAD if count>0, otherwise DONE (done and core_en go high again one cycle later).
- LOAD:
  - rx_ready=1. A byte is accepted when rx_valid&&rx_ready.
  - Byte k of a word (k=0..BPW-1) goes into bits [8k+7:8k]; the first byte received is the LSB.
  - Gaps in rx_valid are allowed; state and partial word are held.
  - Acceptance of byte BPW-1 moves to WRITE.
- WRITE (exactly 1 cycle):
  - pm_we=1, pm_waddr=addr, pm_wdata=assembled word, rx_ready=0.
  - At the end of the cycle: addr+1, count-1, idx=0.
  - Next state is DONE if count reaches 0, otherwise LOAD.
- DONE: core_en=1, done=1, busy=0, rx_ready=0.
- Latency and throughput:
  - pm_we asserts in the cycle immediately after the edge that accepts the last byte of a word.
  - Peak throughput is BPW+1 cycles per word (one bubble per word).
- pm_waddr and pm_wdata are registered and hold their last values while pm_we=0.
- start during LOAD/WRITE is ignored. rx_valid outside LOAD is ignored and no byte is consumed.
- Address wrap: a load of exactly 2^ADDR_W words ends at address 2^ADDR_W-1. addr wrap-around is never written.
- Reset mid-load: the partial word is discarded, no further writes occur, core_en=0, and the loader returns to IDLE. Memory contents already written are untouched.
- core_en falls in the cycle after a restart is accepted in DONE. The core is therefore never enabled while memory is being rewritten.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release, stays IDLE with rx_ready=0 and core_en=0.
2. Two-word load: start, word_count=2; bytes 13 01 20 00 93 01 B0 FF back-to-back.
   - pm_we pulses twice: addr0=0x00200113, then addr1=0xFFB00193.
   - Each pulse is 1 cycle after its 4th byte; rx_ready drops for 1 cycle.
   - done=core_en=1 one cycle after the second write.
3. Throttled stream: same image with rx_valid low for 3 cycles between every byte -> identical writes and data, only later in time; no byte lost or duplicated.
4. word_count=0: start -> no pm_we, rx_ready never asserts, done=core_en=1 two cycles after start.
5. Reset mid-load: word_count=3, assert rst_n=0 after 6 bytes.
   - Exactly one write (addr0), then all outputs 0.
   - A new start with word_count=1 writes addr0 again from fresh bytes.
6. Restart and ignore:
   - start pulses during LOAD are ignored (count unchanged, same 3 writes).
   - After DONE, a new start drops core_en/done the next cycle and reloads from addr0.
